mvm_stream_sequencer: RTL and testbench
=======================================

Name: mvm_stream_sequencer

Overview:
- Controller in front of the matrix-vector TensorUnit datapath.
- Accepts matrix and vector elements as D_WIDTH-bit valid/ready streams and assembles them into the flat operand buses the TensorUnit consumes.
- Issues a single-cycle start, waits for done, captures the flat result, then serializes it out one element per handshake with a last flag.

Parameters:
- D_WIDTH, 32, bits per element.
- M_SIZE, 10, matrix dimension (M_SIZE x M_SIZE matrix, M_SIZE-element vector and result).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- i_matrix_element  in  D_WIDTH  matrix stream data, row-major order.
- i_matrix_is_valid  in  1  matrix stream valid.
- o_ready_to_accept_matrix  out  1  matrix stream ready.
- i_vector_element  in  D_WIDTH  vector stream data, index 0 first.
- i_vector_is_valid  in  1  vector stream valid.
- o_ready_to_accept_vector  out  1  vector stream ready.
- o_matrix  out  D_WIDTH*M_SIZE*M_SIZE  flat matrix to TensorUnit; element (r,c) at bits [(r*M_SIZE+c)*D_WIDTH +: D_WIDTH].
- o_vector  out  D_WIDTH*M_SIZE  flat vector to TensorUnit; element i at [i*D_WIDTH +: D_WIDTH].
- o_start  out  1  one-cycle compute start pulse.
- i_compute_done  in  1  TensorUnit result valid (level or pulse).
- i_result  in  D_WIDTH*M_SIZE  flat result from TensorUnit, same packing as o_vector.
- o_result_element  out  D_WIDTH  result stream data.
- o_result_is_valid  out  1  result stream valid.
- i_receiver_ready_for_result  in  1  result stream ready.
- o_this_is_the_last_result  out  1  high with the final result element.
- o_busy  out  1  high in every state except LOAD_M with zero matrix elements accepted.

Behaviour:
- Clock and reset: one clock aclk; reset areset is synchronous and active-high.
- Transfer rule: a transfer occurs on a rising edge when valid and ready are both high. Readies are pure decodes of the registered state, with no combinational path from inputs.
- States:
  - LOAD_M: matrix ready = 1. Each transfer writes element mcnt, then mcnt++. On transfer with mcnt == M_SIZE*M_SIZE-1, go to LOAD_V and clear mcnt.
  - LOAD_V: vector ready = 1. On transfer with vcnt == M_SIZE-1, go to START and clear vcnt.
  - START: o_start = 1 for exactly this cycle, then WAIT.
  - WAIT: when i_compute_done = 1, latch i_result into the result register, clear rcnt, go to DRAIN. i_compute_done is ignored in every other state.
  - DRAIN: o_result_is_valid = 1; o_result_element = result[rcnt]; o_this_is_the_last_result = (rcnt == M_SIZE-1). Each handshake increments rcnt. The handshake on the last element returns to LOAD_M.
- Latency:
  - Last vector transfer at cycle t gives o_start high at t+1.
  - Done sampled at cycle u gives first result valid at u+1.
  - With receiver ready held high, the drain takes M_SIZE cycles.
- Stream rules:
  - Data, valid and last are held stable while valid && !ready.
  - Valid on the wrong stream, or in a non-load state, is ignored; nothing is written.
  - Back-to-back transfers are sustained at 1 per cycle.
- Operands: o_matrix and o_vector are driven continuously from the registers and stay stable from START through WAIT.
- Widths: mcnt is $clog2(M_SIZE*M_SIZE) bits; vcnt and rcnt are $clog2(M_SIZE) bits, with a minimum of 1 bit each.
- Reset values, including reset asserted mid-operation in any state:
  - State goes to LOAD_M; all counters go to 0.
  - o_matrix, o_vector and the result register go to 0.
  - All outputs are 0 except o_ready_to_accept_matrix, which is 1 from the first cycle after reset is released.
  - A pending result is discarded.

Optional Feature:
- Macro: MVM_MATRIX_REUSE_EN.
- Defined:
  - Adds port i_keep_matrix (in, 1).
  - On the last DRAIN handshake, if i_keep_matrix = 1, go to LOAD_V instead of LOAD_M; o_matrix is retained unchanged and o_busy remains 1.
  - Reset still clears the matrix.
- Undefined: the port is absent, and the block always returns to LOAD_M after a drain.

Decomposition:
- Package mvm_pkg holds:
  - the state enum {LOAD_M, LOAD_V, START, WAIT, DRAIN};
  - localparam count widths derived from M_SIZE;
  - an element-slice helper function for the flat-bus index.
- Sub-module mvm_result_serializer:
  - holds the result register, rcnt, and the valid/ready/last logic;
  - inputs are capture and drain-enable; output is drain_complete.

Test Plan (M_SIZE=10, D_WIDTH=32 unless noted):
- Identity matrix plus vector 1..10, TensorUnit model gives done 3 cycles after o_start. Required: o_start is a single pulse one cycle after the 10th vector transfer; results are 1..10 in order; last is high only on 10; the state returns to LOAD_M with matrix ready = 1.
- Receiver ready toggled 1-0-0-1 during drain. Required: o_result_element and last are held stable while ready is low; no element is skipped or duplicated; exactly 10 handshakes occur.
- Vector valid with data 0xDEADBEEF asserted throughout LOAD_M, and matrix valid pulsed during WAIT. Required: the vector register is unchanged (0), and o_matrix is unchanged during WAIT.
- areset asserted for 1 cycle after 57 matrix elements, then a full fresh job. Required: all outputs are 0 and matrix ready = 1 in the cycle after reset; the fresh job's results are correct with no stale elements.
- i_compute_done held high from reset through LOAD_M and LOAD_V. Required: no capture before WAIT; capture occurs on the first WAIT cycle.
- With MVM_MATRIX_REUSE_EN and i_keep_matrix = 1: two vectors are streamed after a single matrix load. Required: the second job starts with matrix ready = 0, and both result sets are correct.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector stream sequencer.
package mvm_pkg;

    typedef enum logic [2:0] {
        LOAD_M,
        LOAD_V,
        START,
        WAIT,
        DRAIN
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_M_SIZE = 10;
    localparam int unsigned DEF_MCNT_W = cnt_width(DEF_M_SIZE * DEF_M_SIZE);
    localparam int unsigned DEF_RCNT_W = cnt_width(DEF_M_SIZE);

    // LSB position of element idx in a flat bus of w-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/mvm_result_serializer.sv
// Holds the captured TensorUnit result and streams it out one element per handshake.
module mvm_result_serializer
    import mvm_pkg::*;
#(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned M_SIZE  = DEF_M_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        capture,
    input  logic                        drain_en,
    input  logic [D_WIDTH*M_SIZE-1:0]   result_in,
    input  logic                        rx_ready,
    output logic [D_WIDTH-1:0]          element,
    output logic                        valid,
    output logic                        last,
    output logic                        drain_complete
);

    localparam int unsigned RCNT_W = (M_SIZE == DEF_M_SIZE) ? DEF_RCNT_W : cnt_width(M_SIZE);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(M_SIZE - 1);

    logic [D_WIDTH*M_SIZE-1:0] result_q, result_d;
    logic [RCNT_W-1:0]         rcnt_q, rcnt_d;
    logic                      handshake;

    always_comb begin
        result_d       = result_q;
        rcnt_d         = rcnt_q;
        handshake      = drain_en && rx_ready;
        valid          = drain_en;
        last           = drain_en && (rcnt_q == RCNT_LAST);
        drain_complete = handshake && (rcnt_q == RCNT_LAST);
        element        = '0;

        if (drain_en) begin
            for (int unsigned i = 0; i < M_SIZE; i++) begin
                if (rcnt_q == RCNT_W'(i)) begin
                    element = result_q[elem_lsb(i, D_WIDTH) +: D_WIDTH];
                end
            end
        end

        if (capture) begin
            result_d = result_in;
            rcnt_d   = '0;
        end else if (handshake) begin
            rcnt_d = (rcnt_q == RCNT_LAST) ? '0 : rcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            rcnt_q   <= '0;
        end else begin
            result_q <= result_d;
            rcnt_q   <= rcnt_d;
        end
    end

endmodule

// File: rtl/mvm_stream_sequencer.sv
// Stream front-end for the TensorUnit: loads matrix/vector, starts compute, drains result.
// Optional macro MVM_MATRIX_REUSE_EN adds i_keep_matrix to skip matrix reload between jobs.
module mvm_stream_sequencer
    import mvm_pkg::*;
#(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned M_SIZE  = DEF_M_SIZE
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [D_WIDTH-1:0]                  i_matrix_element,
    input  logic                                i_matrix_is_valid,
    output logic                                o_ready_to_accept_matrix,
    input  logic [D_WIDTH-1:0]                  i_vector_element,
    input  logic                                i_vector_is_valid,
    output logic                                o_ready_to_accept_vector,
    output logic [D_WIDTH*M_SIZE*M_SIZE-1:0]    o_matrix,
    output logic [D_WIDTH*M_SIZE-1:0]           o_vector,
    output logic                                o_start,
    input  logic                                i_compute_done,
    input  logic [D_WIDTH*M_SIZE-1:0]           i_result,
    output logic [D_WIDTH-1:0]                  o_result_element,
    output logic                                o_result_is_valid,
    input  logic                                i_receiver_ready_for_result,
    output logic                                o_this_is_the_last_result,
`ifdef MVM_MATRIX_REUSE_EN
    input  logic                                i_keep_matrix,
`endif
    output logic                                o_busy
);

    localparam int unsigned MCNT_W = (M_SIZE == DEF_M_SIZE) ? DEF_MCNT_W : cnt_width(M_SIZE * M_SIZE);
    localparam int unsigned VCNT_W = (M_SIZE == DEF_M_SIZE) ? DEF_RCNT_W : cnt_width(M_SIZE);
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(M_SIZE * M_SIZE - 1);
    localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(M_SIZE - 1);

    state_e                            state_q, state_d;
    logic [MCNT_W-1:0]                 mcnt_q, mcnt_d;
    logic [VCNT_W-1:0]                 vcnt_q, vcnt_d;
    logic [D_WIDTH*M_SIZE*M_SIZE-1:0]  matrix_q, matrix_d;
    logic [D_WIDTH*M_SIZE-1:0]         vector_q, vector_d;
    logic                              capture;
    logic                              drain_en;
    logic                              drain_complete;
    logic                              keep_matrix;

`ifdef MVM_MATRIX_REUSE_EN
    assign keep_matrix = i_keep_matrix;
`else
    assign keep_matrix = 1'b0;
`endif

    always_comb begin
        state_d                  = state_q;
        mcnt_d                   = mcnt_q;
        vcnt_d                   = vcnt_q;
        matrix_d                 = matrix_q;
        vector_d                 = vector_q;
        capture                  = 1'b0;
        drain_en                 = (state_q == DRAIN);
        o_ready_to_accept_matrix = (state_q == LOAD_M);
        o_ready_to_accept_vector = (state_q == LOAD_V);
        o_start                  = (state_q == START);
        o_busy                   = !((state_q == LOAD_M) && (mcnt_q == '0));

        case (state_q)
            LOAD_M: begin
                if (i_matrix_is_valid) begin
                    for (int unsigned k = 0; k < M_SIZE * M_SIZE; k++) begin
                        if (mcnt_q == MCNT_W'(k)) begin
                            matrix_d[elem_lsb(k, D_WIDTH) +: D_WIDTH] = i_matrix_element;
                        end
                    end
                    if (mcnt_q == MCNT_LAST) begin
                        mcnt_d  = '0;
                        state_d = LOAD_V;
                    end else begin
                        mcnt_d = mcnt_q + 1'b1;
                    end
                end
            end
            LOAD_V: begin
                if (i_vector_is_valid) begin
                    for (int unsigned i = 0; i < M_SIZE; i++) begin
                        if (vcnt_q == VCNT_W'(i)) begin
                            vector_d[elem_lsb(i, D_WIDTH) +: D_WIDTH] = i_vector_element;
                        end
                    end
                    if (vcnt_q == VCNT_LAST) begin
                        vcnt_d  = '0;
                        state_d = START;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (i_compute_done) begin
                    capture = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_complete) begin
                    state_d = keep_matrix ? LOAD_V : LOAD_M;
                end
            end
            default: state_d = LOAD_M;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= LOAD_M;
            mcnt_q   <= '0;
            vcnt_q   <= '0;
            matrix_q <= '0;
            vector_q <= '0;
        end else begin
            state_q  <= state_d;
            mcnt_q   <= mcnt_d;
            vcnt_q   <= vcnt_d;
            matrix_q <= matrix_d;
            vector_q <= vector_d;
        end
    end

    assign o_matrix = matrix_q;
    assign o_vector = vector_q;

    mvm_result_serializer #(
        .D_WIDTH (D_WIDTH),
        .M_SIZE  (M_SIZE)
    ) u_serializer (
        .clk            (aclk),
        .rst            (areset),
        .capture        (capture),
        .drain_en       (drain_en),
        .result_in      (i_result),
        .rx_ready       (i_receiver_ready_for_result),
        .element        (o_result_element),
        .valid          (o_result_is_valid),
        .last           (o_this_is_the_last_result),
        .drain_complete (drain_complete)
    );

endmodule

// File: tb/tb_mvm_stream_sequencer.sv
// Directed self-checking bench for mvm_stream_sequencer (M_SIZE=10, D_WIDTH=32).
module tb_mvm_stream_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned MS = 10;
    localparam int unsigned MN = MS * MS;

    logic               aclk = 1'b0;
    logic               areset = 1'b0;
    logic [DW-1:0]      i_matrix_element = '0;
    logic               i_matrix_is_valid = 1'b0;
    logic               o_ready_to_accept_matrix;
    logic [DW-1:0]      i_vector_element = '0;
    logic               i_vector_is_valid = 1'b0;
    logic               o_ready_to_accept_vector;
    logic [DW*MN-1:0]   o_matrix;
    logic [DW*MS-1:0]   o_vector;
    logic               o_start;
    logic               i_compute_done = 1'b0;
    logic [DW*MS-1:0]   i_result = '0;
    logic [DW-1:0]      o_result_element;
    logic               o_result_is_valid;
    logic               i_receiver_ready_for_result = 1'b0;
    logic               o_this_is_the_last_result;
    logic               o_busy;
`ifdef MVM_MATRIX_REUSE_EN
    logic               i_keep_matrix = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]      mat  [MN];
    logic [DW-1:0]      vec  [MS];
    logic [DW-1:0]      rexp [MS];
    logic [DW*MN-1:0]   exp_m;
    logic [DW*MS-1:0]   exp_v;
    logic [DW*MS-1:0]   exp_r;

    mvm_stream_sequencer #(
        .D_WIDTH (DW),
        .M_SIZE  (MS)
    ) dut (
        .aclk                        (aclk),
        .areset                      (areset),
        .i_matrix_element            (i_matrix_element),
        .i_matrix_is_valid           (i_matrix_is_valid),
        .o_ready_to_accept_matrix    (o_ready_to_accept_matrix),
        .i_vector_element            (i_vector_element),
        .i_vector_is_valid           (i_vector_is_valid),
        .o_ready_to_accept_vector    (o_ready_to_accept_vector),
        .o_matrix                    (o_matrix),
        .o_vector                    (o_vector),
        .o_start                     (o_start),
        .i_compute_done              (i_compute_done),
        .i_result                    (i_result),
        .o_result_element            (o_result_element),
        .o_result_is_valid           (o_result_is_valid),
        .i_receiver_ready_for_result (i_receiver_ready_for_result),
        .o_this_is_the_last_result   (o_this_is_the_last_result),
`ifdef MVM_MATRIX_REUSE_EN
        .i_keep_matrix               (i_keep_matrix),
`endif
        .o_busy                      (o_busy)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Reference product and flat buses built from the bench's own arrays.
    task automatic build_expected();
        logic [DW-1:0] acc;
        for (int r = 0; r < MS; r++) begin
            acc = '0;
            for (int c = 0; c < MS; c++) acc = acc + mat[r*MS+c] * vec[c];
            rexp[r] = acc;
        end
        for (int k = 0; k < MN; k++) exp_m[k*DW +: DW] = mat[k];
        for (int i = 0; i < MS; i++) begin
            exp_v[i*DW +: DW] = vec[i];
            exp_r[i*DW +: DW] = rexp[i];
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
    endtask

    task automatic send_matrix();
        for (int k = 0; k < MN; k++) begin
            i_matrix_element  = mat[k];
            i_matrix_is_valid = 1'b1;
            checks++;
            if (o_ready_to_accept_matrix !== 1'b1) begin
                errors++;
                $display("FAIL matrix_ready elem %0d: got %b want 1", k, o_ready_to_accept_matrix);
            end
            step();
        end
        i_matrix_is_valid = 1'b0;
        i_vector_is_valid = 1'b0;
    endtask

    task automatic send_vector();
        for (int i = 0; i < MS; i++) begin
            i_vector_element  = vec[i];
            i_vector_is_valid = 1'b1;
            checks++;
            if (o_ready_to_accept_vector !== 1'b1 || o_start !== 1'b0) begin
                errors++;
                $display("FAIL vector_ready elem %0d: got ready=%b start=%b want ready=1 start=0",
                         i, o_ready_to_accept_vector, o_start);
            end
            step();
        end
        i_vector_is_valid = 1'b0;
    endtask

    // Entered in the START cycle; models a TensorUnit raising done 3 cycles after start.
    task automatic run_compute(input bit pulse_matrix);
        checks++;
        if (o_start !== 1'b1 || o_matrix !== exp_m || o_vector !== exp_v) begin
            errors++;
            $display("FAIL start_operands: got start=%b m0=%h v=%h want start=1 m0=%h v=%h",
                     o_start, o_matrix[DW-1:0], o_vector, exp_m[DW-1:0], exp_v);
        end
        for (int w = 0; w < 3; w++) begin
            if (pulse_matrix && w < 2) begin
                i_matrix_element  = 32'hFFFF_FFFF;
                i_matrix_is_valid = 1'b1;
            end else begin
                i_matrix_is_valid = 1'b0;
            end
            step();
            checks++;
            if (o_start !== 1'b0 || o_result_is_valid !== 1'b0 || o_matrix !== exp_m
                || o_ready_to_accept_matrix !== 1'b0) begin
                errors++;
                $display("FAIL wait_state cyc %0d: got start=%b valid=%b mready=%b m0=%h want 0 0 0 %h",
                         w, o_start, o_result_is_valid, o_ready_to_accept_matrix,
                         o_matrix[DW-1:0], exp_m[DW-1:0]);
            end
        end
        i_matrix_is_valid = 1'b0;
        i_compute_done    = 1'b1;
        i_result          = exp_r;
        step();
        i_compute_done    = 1'b0;
        i_result          = '0;
    endtask

    task automatic drain(input bit toggle, output int cycles);
        int n;
        bit rdy;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        n = 0;
        cycles = 0;
        while (n < MS && cycles < 40) begin
            rdy = toggle ? pat[cycles % 4] : 1'b1;
            i_receiver_ready_for_result = rdy;
            checks++;
            if (o_result_is_valid !== 1'b1 || o_result_element !== rexp[n]
                || o_this_is_the_last_result !== (n == MS - 1)) begin
                errors++;
                $display("FAIL drain idx %0d: got valid=%b data=%h last=%b want 1 %h %b",
                         n, o_result_is_valid, o_result_element, o_this_is_the_last_result,
                         rexp[n], (n == MS - 1));
            end
            step();
            if (rdy) n++;
            cycles++;
        end
        i_receiver_ready_for_result = 1'b0;
        checks++;
        if (n != MS) begin
            errors++;
            $display("FAIL drain_timeout: got %0d handshakes want %0d", n, MS);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (o_result_is_valid !== 1'b0 || o_ready_to_accept_matrix !== 1'b1
            || o_ready_to_accept_vector !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got valid=%b mready=%b vready=%b busy=%b want 0 1 0 0",
                     tag, o_result_is_valid, o_ready_to_accept_matrix,
                     o_ready_to_accept_vector, o_busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_matrix !== '0 || o_vector !== '0 || o_start !== 1'b0 || o_result_element !== '0
            || o_this_is_the_last_result !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got m0=%h v0=%h start=%b data=%h last=%b want all 0",
                     o_matrix[DW-1:0], o_vector[DW-1:0], o_start, o_result_element,
                     o_this_is_the_last_result);
        end
        check_idle("reset");
    endtask

    task automatic test_identity();
        int cyc;
        for (int k = 0; k < MN; k++) mat[k] = ((k / MS) == (k % MS)) ? 32'd1 : 32'd0;
        for (int i = 0; i < MS; i++) vec[i] = 32'(i + 1);
        build_expected();
        send_matrix();
        checks++;
        if (o_busy !== 1'b1 || o_ready_to_accept_vector !== 1'b1 || o_ready_to_accept_matrix !== 1'b0) begin
            errors++;
            $display("FAIL load_v_entry: got busy=%b vready=%b mready=%b want 1 1 0",
                     o_busy, o_ready_to_accept_vector, o_ready_to_accept_matrix);
        end
        send_vector();
        run_compute(1'b0);
        drain(1'b0, cyc);
        checks++;
        if (cyc != MS) begin
            errors++;
            $display("FAIL drain_cycles: got %0d want %0d", cyc, MS);
        end
        check_idle("identity");
    endtask

    task automatic test_back_to_back_backpressure();
        int cyc;
        for (int k = 0; k < MN; k++) mat[k] = 32'(k * 3 + 1);
        for (int i = 0; i < MS; i++) vec[i] = 32'(MS - i);
        build_expected();
        send_matrix();
        send_vector();
        run_compute(1'b0);
        drain(1'b1, cyc);
        check_idle("backpressure");
    endtask

    task automatic test_wrong_stream();
        int cyc;
        do_reset();
        for (int k = 0; k < MN; k++) mat[k] = 32'(k) ^ 32'h5555_0000;
        for (int i = 0; i < MS; i++) vec[i] = 32'(i * 7 + 2);
        build_expected();
        i_vector_element  = 32'hDEAD_BEEF;
        i_vector_is_valid = 1'b1;
        send_matrix();
        checks++;
        if (o_vector !== '0 || o_matrix !== exp_m) begin
            errors++;
            $display("FAIL vector_noise: got v=%h m0=%h want v=0 m0=%h",
                     o_vector, o_matrix[DW-1:0], exp_m[DW-1:0]);
        end
        send_vector();
        run_compute(1'b1);
        drain(1'b0, cyc);
        check_idle("wrong_stream");
    endtask

    task automatic test_midop_reset();
        int cyc;
        for (int k = 0; k < 57; k++) begin
            i_matrix_element  = 32'hAAAA_0000 + 32'(k);
            i_matrix_is_valid = 1'b1;
            step();
        end
        i_matrix_is_valid = 1'b0;
        areset = 1'b1;
        step();
        areset = 1'b0;
        checks++;
        if (o_matrix !== '0 || o_vector !== '0 || o_start !== 1'b0 || o_result_is_valid !== 1'b0
            || o_result_element !== '0 || o_this_is_the_last_result !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset_outputs: got m0=%h m56=%h start=%b valid=%b want all 0",
                     o_matrix[DW-1:0], o_matrix[56*DW +: DW], o_start, o_result_is_valid);
        end
        check_idle("midop_reset");
        for (int k = 0; k < MN; k++) mat[k] = 32'(k + 1);
        for (int i = 0; i < MS; i++) vec[i] = 32'(i + 2);
        build_expected();
        send_matrix();
        send_vector();
        run_compute(1'b0);
        drain(1'b0, cyc);
        check_idle("fresh_job");
    endtask

    task automatic test_done_held();
        int cyc;
        i_compute_done = 1'b1;
        i_result       = {MS{32'h1111_1111}};
        do_reset();
        for (int k = 0; k < MN; k++) mat[k] = 32'(k % 4);
        for (int i = 0; i < MS; i++) vec[i] = 32'(i + 5);
        build_expected();
        send_matrix();
        checks++;
        if (o_result_is_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_held_load_m: got valid=%b want 0", o_result_is_valid);
        end
        send_vector();
        checks++;
        if (o_start !== 1'b1 || o_result_is_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_held_start: got start=%b valid=%b want 1 0", o_start, o_result_is_valid);
        end
        step();
        i_result = exp_r;
        checks++;
        if (o_result_is_valid !== 1'b0 || o_start !== 1'b0) begin
            errors++;
            $display("FAIL done_held_wait: got valid=%b start=%b want 0 0", o_result_is_valid, o_start);
        end
        step();
        drain(1'b0, cyc);
        i_compute_done = 1'b0;
        i_result       = '0;
        check_idle("done_held");
    endtask

`ifdef MVM_MATRIX_REUSE_EN
    task automatic test_reuse();
        int cyc;
        do_reset();
        for (int k = 0; k < MN; k++) mat[k] = 32'(k * 5 + 3);
        for (int i = 0; i < MS; i++) vec[i] = 32'(i + 1);
        build_expected();
        i_keep_matrix = 1'b1;
        send_matrix();
        send_vector();
        run_compute(1'b0);
        drain(1'b0, cyc);
        checks++;
        if (o_ready_to_accept_matrix !== 1'b0 || o_ready_to_accept_vector !== 1'b1
            || o_busy !== 1'b1 || o_matrix !== exp_m) begin
            errors++;
            $display("FAIL reuse_entry: got mready=%b vready=%b busy=%b m0=%h want 0 1 1 %h",
                     o_ready_to_accept_matrix, o_ready_to_accept_vector, o_busy,
                     o_matrix[DW-1:0], exp_m[DW-1:0]);
        end
        for (int i = 0; i < MS; i++) vec[i] = 32'(100 - i * 3);
        build_expected();
        i_keep_matrix = 1'b0;
        send_vector();
        run_compute(1'b0);
        drain(1'b0, cyc);
        check_idle("reuse");
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_back_to_back_backpressure();
        test_wrong_stream();
        test_midop_reset();
        test_done_held();
`ifdef MVM_MATRIX_REUSE_EN
        test_reuse();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
